// File: rtl/hazard_pkg.sv
// Shared types and defaults for the load-use / branch / memory-wait stall unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } state_e;

  localparam int unsigned ZERO_REG_DEFAULT    = 31;
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;
  localparam int unsigned CNT_W_DEFAULT       = 16;
  localparam int unsigned BUSY_CNT_W          = 8;

  function automatic logic srcMatch(input logic uses, input logic [4:0] src,
                                    input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !(&count_q)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: memory freeze beats branch flush beats load-use stall.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int unsigned ZERO_REG    = ZERO_REG_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_WriteRegister,
  input  logic [4:0]       IFID_rm,
  input  logic [4:0]       IFID_rn,
  input  logic             IFID_UsesRm,
  input  logic             IFID_UsesRn,
  input  logic             BranchTaken,
  input  logic             DMem_Busy,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             PipeFreeze,
  output logic [CNT_W-1:0] StallCount,
  output logic             MemTimeout
);

  localparam logic [4:0]            ZeroIdx    = ZERO_REG[4:0];
  localparam logic [BUSY_CNT_W-1:0] TimeoutThr = BUSY_CNT_W'(MEM_TIMEOUT - 1);

  state_e                state_q;
  state_e                state_d;
  logic                  memTimeout_q;
  logic                  memTimeout_d;
  logic [BUSY_CNT_W-1:0] busyCnt;

  logic hazard;
  logic hazardMasked;
  logic pcWrite;
  logic ifidWrite;
  logic idexBubble;
  logic flush;
  logic freeze;

  assign hazard = IDEX_MemRead && (IDEX_WriteRegister != ZeroIdx) &&
                  (srcMatch(IFID_UsesRm, IFID_rm, IDEX_WriteRegister) ||
                   srcMatch(IFID_UsesRn, IFID_rn, IDEX_WriteRegister));

  // The cycle after a stall or a flush already has the dependent/NOP instruction sorted out.
  assign hazardMasked = (state_q == ST_LOAD_STALL) || (state_q == ST_FLUSH);

  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    idexBubble = 1'b0;
    flush      = 1'b0;
    freeze     = 1'b0;
    state_d    = ST_RUN;
    if (DMem_Busy) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      freeze    = 1'b1;
      state_d   = ST_MEM_WAIT;
    end else if (BranchTaken) begin
      flush   = 1'b1;
      state_d = ST_FLUSH;
    end else if (hazard && !hazardMasked) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
      state_d    = ST_LOAD_STALL;
    end
  end

  assign memTimeout_d = memTimeout_q | (DMem_Busy && (busyCnt >= TimeoutThr));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_RUN;
      memTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      memTimeout_q <= memTimeout_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .clr_i   (1'b0),
    .inc_i   (!pcWrite),
    .count_o (StallCount)
  );

  sat_counter #(.WIDTH(BUSY_CNT_W)) u_busy_cnt (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .clr_i   (!DMem_Busy),
    .inc_i   (DMem_Busy),
    .count_o (busyCnt)
  );

  // Reset forces every control output low at once, independent of the clock.
  assign PCWrite     = Reset_n & pcWrite;
  assign IFID_Write  = Reset_n & ifidWrite;
  assign IDEX_Bubble = Reset_n & idexBubble;
  assign IFID_Flush  = Reset_n & flush;
  assign IDEX_Flush  = Reset_n & flush;
  assign PipeFreeze  = Reset_n & freeze;
  assign MemTimeout  = memTimeout_q;

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, busy cycles before MemTimeout sets (1..255).
REQ-002 SHALL have parameter ZERO_REG, default 31, register index never causing a hazard (XZR).
REQ-003 SHALL have parameter CNT_W, default 16, StallCount width.
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 IDEX_MemRead  input  1  instruction in ID/EX is a load.
REQ-007 IDEX_WriteRegister  input  5  load destination.
REQ-008 IFID_rm, IFID_rn  input  5 each  source registers of the instruction in IF/ID.
REQ-009 IFID_UsesRm, IFID_UsesRn  input  1 each  the corresponding source is actually read.
REQ-010 BranchTaken  input  1  branch resolved taken this cycle.
REQ-011 DMem_Busy  input  1  data memory not ready; pipeline must freeze.
REQ-012 PCWrite, IFID_Write  output  1 each  PC / IF/ID register load enables.
REQ-013 IDEX_Bubble  output  1  zero ID/EX control fields.
REQ-014 IFID_Flush, IDEX_Flush  output  1 each  clear register to NOP.
REQ-015 PipeFreeze  output  1  hold all pipeline registers.
REQ-016 StallCount  output  CNT_W  stall-cycle statistic.
REQ-017 MemTimeout  output  1  sticky memory-timeout error.

Function
REQ-018 Hazard = IDEX_MemRead & IDEX_WriteRegister!=ZERO_REG & ((IFID_UsesRm & match rm) | (IFID_UsesRn & match rn)).
REQ-019 States RUN, LOAD_STALL, FLUSH, MEM_WAIT; control outputs combinational from state and current inputs (same-cycle effect, zero latency).
REQ-020 Priority in any state: DMem_Busy > BranchTaken > Hazard.
REQ-021 DMem_Busy=1: PipeFreeze=1, PCWrite=0, IFID_Write=0, no flush/bubble; next state MEM_WAIT.
REQ-022 MEM_WAIT with DMem_Busy=0: behave as RUN this cycle; next state from RUN rules.
REQ-023 BranchTaken=1 (not busy): PCWrite=1, IFID_Flush=1, IDEX_Flush=1, IDEX_Bubble=0; next state FLUSH.
REQ-024 FLUSH: Hazard ignored (IF/ID holds NOP); outputs as RUN idle; next RUN unless busy/branch.
REQ-025 Hazard in RUN/MEM_WAIT: PCWrite=0, IFID_Write=0, IDEX_Bubble=1; next state LOAD_STALL.
REQ-026 LOAD_STALL: Hazard masked, idle outputs; next RUN (exactly one stall cycle per load-use).
REQ-027 RUN idle: PCWrite=1, IFID_Write=1, all others 0.
REQ-028 StallCount increments by 1 every cycle PCWrite=0; saturates at all-ones.
REQ-029 Busy counter increments each DMem_Busy cycle, clears when DMem_Busy=0; reaching MEM_TIMEOUT sets MemTimeout, held until reset; counter saturates.
REQ-030 Simultaneous BranchTaken and Hazard: flush only, no stall, StallCount unchanged.

Reset
REQ-031 Reset_n=0 SHALL immediately force state RUN, StallCount=0, busy counter=0, MemTimeout=0, PCWrite=0, IFID_Write=0, all other outputs 0.
REQ-032 Reset assertion mid-MEM_WAIT or mid-LOAD_STALL SHALL abandon the operation; first edge after release evaluates as RUN.

Structure
REQ-033 hazard_pkg SHALL hold the state enumeration and ZERO_REG default.
REQ-034 One sub-module sat_counter (parameterised width, inc, clr, saturate) SHALL implement StallCount and busy counter.

Verification
REQ-035 Load X3 in ID/EX, IF/ID rn=X3 UsesRn=1 -> one cycle PCWrite=0, IDEX_Bubble=1, StallCount 0->1, then RUN.
REQ-036 Load to X31, IF/ID rm=31 UsesRm=1 -> no stall, PCWrite=1.
REQ-037 BranchTaken with concurrent hazard -> IFID_Flush=IDEX_Flush=1, PCWrite=1, next cycle hazard masked, StallCount=0.
REQ-038 DMem_Busy high 255 cycles, MEM_TIMEOUT=255 -> PipeFreeze=1 throughout, MemTimeout=1 after cycle 255, stays 1 after busy drops.
REQ-039 Reset_n pulled low mid-MEM_WAIT -> outputs to reset values asynchronously, MemTimeout=0, RUN after release.
REQ-040 CNT_W=4, 16 stall cycles -> StallCount saturates at 15.
